// File: rtl/frame_serializer_tx_if.sv
// Upstream frame handshake and downstream word handshake for frame_serializer_tx.
// down_last exists only when FRAME_SER_LAST_EN is defined.
interface frame_serializer_tx_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic                         up_valid;
    logic                         up_ready;
    logic [DEPTH-1:0][WIDTH-1:0]  up_data;
    logic [LW-1:0]                up_len;
    logic                         down_valid;
    logic                         down_ready;
    logic [WIDTH-1:0]             down_data;
`ifdef FRAME_SER_LAST_EN
    logic                         down_last;

    // master: frame source and word sink; slave: the serializer
    modport master (
        output up_valid, up_data, up_len, down_ready,
        input  up_ready, down_valid, down_data, down_last
    );
    modport slave (
        input  up_valid, up_data, up_len, down_ready,
        output up_ready, down_valid, down_data, down_last
    );
`else
    modport master (
        output up_valid, up_data, up_len, down_ready,
        input  up_ready, down_valid, down_data
    );
    modport slave (
        input  up_valid, up_data, up_len, down_ready,
        output up_ready, down_valid, down_data
    );
`endif
endinterface

// File: rtl/frame_serializer_tx.sv
// Double-buffered frame-to-word serializer for the UART TX path.
// Optional macro FRAME_SER_LAST_EN adds the down_last frame-boundary marker.
module frame_serializer_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    frame_serializer_tx_if.slave    bus,
    output logic                    busy
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] data_q [2];
    logic [DEPTH-1:0][WIDTH-1:0] data_d [2];
    logic [LW-1:0]               len_q  [2];
    logic [LW-1:0]               len_d  [2];
    logic [1:0]                  full_q, full_d;
    logic                        wb_q, wb_d;
    logic                        rb_q, rb_d;
    logic [IW-1:0]               idx_q, idx_d;

    logic                        accept_c;
    logic                        down_hs_c;
    logic                        last_c;
    logic [LW-1:0]               eff_len_c;

    // Zero and over-range lengths both mean a full DEPTH-word frame
    always_comb begin
        eff_len_c = bus.up_len;
        if ((bus.up_len == LW'(0)) || (bus.up_len > LW'(DEPTH))) begin
            eff_len_c = LW'(DEPTH);
        end
    end

    assign last_c    = (LW'(idx_q) == (len_q[rb_q] - LW'(1)));
    assign accept_c  = bus.up_valid & ~full_q[wb_q];
    assign down_hs_c = full_q[rb_q] & bus.down_ready;

    // Accept only targets an empty bank and release only a full one, so they never collide
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        idx_d  = idx_q;
        if (accept_c) begin
            data_d[wb_q] = bus.up_data;
            len_d[wb_q]  = eff_len_c;
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        if (down_hs_c) begin
            if (last_c) begin
                full_d[rb_q] = 1'b0;
                idx_d        = IW'(0);
                rb_d         = ~rb_q;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                data_q[b] <= '0;
                len_q[b]  <= '0;
            end
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            idx_q  <= IW'(0);
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            idx_q  <= idx_d;
        end
    end

    // All outputs are decoded straight from state registers
    assign bus.up_ready   = ~full_q[wb_q];
    assign bus.down_valid = full_q[rb_q];
    assign bus.down_data  = data_q[rb_q][idx_q];
    assign busy           = full_q[0] | full_q[1];
`ifdef FRAME_SER_LAST_EN
    assign bus.down_last  = full_q[rb_q] & last_c;
`endif

endmodule
